wb_stream_dma_rd: RTL

WB_STREAM_DMA_RD -- requirements
Module: wb_stream_dma_rd

---
 rtl/wb_stream_dma_rd.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_stream_dma_rd.sv
// Wishbone burst reader: streams a memory buffer into a downstream FIFO, one burst at a time.
// Define WB_STREAM_DMA_RD_CIRCULAR_EN to loop over the buffer until enable_i drops.
module wb_stream_dma_rd #(
  parameter int unsigned WB_AW   = 32,
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned FIFO_AW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [WB_AW-1:0]     start_adr_i,
  input  logic [23:0]          buf_size_i,
  input  logic [7:0]           burst_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [FIFO_AW:0]     fifo_cnt_i,
  output logic [WB_DW-1:0]     stream_m_data_o,
  output logic                 stream_m_valid_o,
  output logic [WB_AW-1:0]     wbm_adr_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, ABORT} state_t;

  localparam int unsigned       DEPTH    = 1 << FIFO_AW;
  localparam logic [WB_AW-1:0]  ADR_STEP = WB_AW'(WB_DW / 8);

  state_t            state_q;
  logic              en_q;
  logic [WB_AW-1:0]  adr_q;
  logic [23:0]       rem_q;
  logic [7:0]        blen_q;
  logic [7:0]        left_q;
  logic              cyc_q;
  logic [2:0]        cti_q;
  logic              done_q;
  logic              err_q;
`ifdef WB_STREAM_DMA_RD_CIRCULAR_EN
  logic [WB_AW-1:0]  base_q;
  logic [23:0]       size_q;
`endif

  logic [7:0]  beat_d;
  logic [31:0] need_d;
  logic        fits_d;

  assign beat_d = (rem_q < {16'd0, blen_q}) ? rem_q[7:0] : blen_q;
  // Only one burst is ever outstanding, so checking room for the whole burst up front prevents overflow.
  assign need_d = 32'(fifo_cnt_i) + 32'(beat_d);
  assign fits_d = (need_d <= DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      adr_q   <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      left_q  <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_STREAM_DMA_RD_CIRCULAR_EN
      base_q  <= '0;
      size_q  <= '0;
`endif
    end else begin
      en_q   <= enable_i;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && !en_q) begin
            adr_q  <= start_adr_i;
            rem_q  <= buf_size_i;
            blen_q <= (burst_len_i == 8'd0) ? 8'd1 : burst_len_i;
            err_q  <= 1'b0;
`ifdef WB_STREAM_DMA_RD_CIRCULAR_EN
            base_q <= start_adr_i;
            size_q <= buf_size_i;
`endif
            if (buf_size_i == 24'd0) done_q <= 1'b1;
            else                     state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!enable_i) begin
            state_q <= IDLE;
          end else if (fits_d) begin
            state_q <= BURST;
            cyc_q   <= 1'b1;
            left_q  <= beat_d;
            cti_q   <= (beat_d == 8'd1) ? 3'b111 : 3'b010;
          end
        end
        BURST: begin
          if (wbm_err_i) begin
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
            cti_q   <= '0;
            state_q <= ABORT;
          end else if (wbm_ack_i) begin
            adr_q  <= adr_q + ADR_STEP;
            rem_q  <= rem_q - 24'd1;
            left_q <= left_q - 8'd1;
            if (left_q == 8'd1) begin
              cyc_q <= 1'b0;
              cti_q <= '0;
              if (rem_q == 24'd1) begin
                done_q <= 1'b1;
`ifdef WB_STREAM_DMA_RD_CIRCULAR_EN
                adr_q   <= base_q;
                rem_q   <= size_q;
                state_q <= enable_i ? WAIT : IDLE;
`else
                state_q <= IDLE;
`endif
              end else begin
                state_q <= enable_i ? WAIT : IDLE;
              end
            end else begin
              cti_q <= (left_q == 8'd2) ? 3'b111 : 3'b010;
            end
          end
        end
        ABORT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign err_o            = err_q;
  // Zero-latency push: the acked word goes straight through; masked while reset is held.
  assign stream_m_valid_o = rst && (state_q == BURST) && wbm_ack_i && !wbm_err_i;
  assign stream_m_data_o  = stream_m_valid_o ? wbm_dat_i : '0;
  assign wbm_adr_o        = adr_q;
  assign wbm_sel_o        = cyc_q ? '1 : '0;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = cyc_q;
  assign wbm_stb_o        = cyc_q;
  assign wbm_cti_o        = cti_q;
  assign wbm_bte_o        = 2'b00;

endmodule
